// File: rtl/icache_fill_if.sv
// icache_fill_if -- bundles the datapath-side and memory-controller-side
// signals of the instruction cache fill block.
//   slave  modport : the cache (icache_fill)
//   master modport : whatever drives the cache (datapath + memory controller)
// Datapath side : imemREN, imemaddr, flush -> cache ; ihit, imemload <- cache
// Memory side   : iREN, iaddr <- cache ; iwait, iload -> cache
interface icache_fill_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_fill.sv
// icache_fill -- direct-mapped, one-word-per-frame instruction cache with a
// single outstanding fill to the memory controller.
// Ports:
//   CLK, RST       clock and synchronous active-high reset
//   bus            icache_fill_if.slave (datapath request/response and
//                  memory controller read channel)
//   hit_count      saturating count of cycles with ihit asserted
//   miss_count     saturating count of IDLE->FETCH transitions
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | serve hits combinationally; a miss launches a fetch
// FETCH | iREN asserted for the current address until iwait drops
module icache_fill #(
    parameter int NSETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    icache_fill_if.slave bus,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int IW = $clog2(NSETS);
    localparam int TW = 30 - IW;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t          state, next_state;
    logic [NSETS-1:0] valid;
    logic [TW-1:0]   tag_arr  [NSETS];
    logic [31:0]     data_arr [NSETS];

    logic [IW-1:0]   index;
    logic [TW-1:0]   tag;
    logic            hit;
    logic            ihit_c;
    logic            iren_c;
    logic            fill;
    logic            miss_start;
    logic            unused_offset;

    assign index = bus.imemaddr[IW+1:2];
    assign tag   = bus.imemaddr[31:IW+2];
    assign unused_offset = ^bus.imemaddr[1:0];

    assign hit    = bus.imemREN && valid[index] && (tag_arr[index] == tag);
    assign ihit_c = hit && !bus.flush && !RST;

    assign bus.ihit     = ihit_c;
    assign bus.imemload = ihit_c ? data_arr[index] : 32'h0;
    assign bus.iREN     = iren_c;
    // Fetch always follows the live address, so a retarget during FETCH
    // simply changes what gets filled.
    assign bus.iaddr    = {bus.imemaddr[31:2], 2'b00};

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        iren_c     = 1'b0;
        fill       = 1'b0;
        miss_start = 1'b0;
        case (state)
            IDLE: begin
                if (bus.imemREN && !hit && !bus.flush) begin
                    next_state = FETCH;
                    miss_start = 1'b1;
                end
            end
            FETCH: begin
                if (bus.flush || !bus.imemREN) begin
                    next_state = IDLE;
                end else begin
                    iren_c = 1'b1;
                    if (!bus.iwait) begin
                        fill       = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        // Reset wins over everything, including a fill landing this edge.
        if (RST) begin
            iren_c     = 1'b0;
            fill       = 1'b0;
            miss_start = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            valid <= '0;
        else if (bus.flush)
            valid <= '0;
        else if (fill)
            valid[index] <= 1'b1;
    end

    // Tag/data need no reset: a frame is only ever read behind its valid bit.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_arr[index]  <= tag;
            data_arr[index] <= bus.iload;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= 16'h0;
            miss_count <= 16'h0;
        end else begin
            if (ihit_c && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'h1;
            if (miss_start && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'h1;
        end
    end
endmodule

// File: tb/tb_icache_fill.sv
module tb_icache_fill;
    logic        CLK;
    logic        RST;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    int          errors = 0;
    int          checks = 0;

    icache_fill_if bus();

    icache_fill #(.NSETS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(negedge CLK);
    endtask

    // Miss, one-cycle fill, then release the request (three cycles).
    task automatic fill(input logic [31:0] a, input logic [31:0] d);
        cyc(); bus.imemREN = 1'b1; bus.imemaddr = a; bus.iwait = 1'b1;
        cyc(); bus.iwait = 1'b0; bus.iload = d;
        cyc(); bus.iwait = 1'b1; bus.imemREN = 1'b0; bus.iload = 32'h0;
    endtask

    task automatic test_reset();
        RST = 1'b1; bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
        bus.flush = 1'b0; bus.iwait = 1'b1; bus.iload = 32'h0;
        cyc(); cyc(); #1;
        checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL rst_iren: got %b exp 0", bus.iREN); end
        checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL rst_ihit: got %b exp 0", bus.ihit); end
        checks++; if (bus.imemload !== 32'h0) begin errors++; $display("FAIL rst_imemload: got %h exp 0", bus.imemload); end
        cyc(); RST = 1'b0; bus.imemREN = 1'b0; #1;
        checks++; if (hit_count !== 16'h0) begin errors++; $display("FAIL rst_hits: got %0d exp 0", hit_count); end
        checks++; if (miss_count !== 16'h0) begin errors++; $display("FAIL rst_misses: got %0d exp 0", miss_count); end
    endtask

    task automatic test_cold_miss();
        cyc(); bus.imemREN = 1'b1; bus.imemaddr = 32'h40; bus.iwait = 1'b1; #1;
        checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL cold_ihit0: got %b exp 0", bus.ihit); end
        checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL cold_iren_idle: got %b exp 0", bus.iREN); end
        checks++; if (bus.iaddr !== 32'h40) begin errors++; $display("FAIL cold_iaddr: got %h exp 00000040", bus.iaddr); end
        cyc(); #1;
        checks++; if (bus.iREN !== 1'b1) begin errors++; $display("FAIL cold_iren_rise: got %b exp 1", bus.iREN); end
        checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL cold_misses: got %0d exp 1", miss_count); end
        cyc(); cyc();
        cyc(); bus.iwait = 1'b0; bus.iload = 32'hDEAD_BEEF; #1;
        checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL cold_ihit_fillcyc: got %b exp 0", bus.ihit); end
        checks++; if (bus.iREN !== 1'b1) begin errors++; $display("FAIL cold_iren_fillcyc: got %b exp 1", bus.iREN); end
        cyc(); bus.iwait = 1'b1; bus.iload = 32'h0; #1;
        checks++; if (bus.ihit !== 1'b1) begin errors++; $display("FAIL cold_ihit: got %b exp 1", bus.ihit); end
        checks++; if (bus.imemload !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cold_data: got %h exp deadbeef", bus.imemload); end
        checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL cold_iren_after: got %b exp 0", bus.iREN); end
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL cold_hits0: got %0d exp 0", hit_count); end
        cyc(); #1;
        checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL cold_hits1: got %0d exp 1", hit_count); end
        cyc(); bus.imemREN = 1'b0; #1;
        checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL cold_hits2: got %0d exp 2", hit_count); end
        checks++; if (bus.imemload !== 32'h0) begin errors++; $display("FAIL cold_load_idle: got %h exp 0", bus.imemload); end
    endtask

    task automatic test_conflict();
        cyc(); bus.imemREN = 1'b1; bus.imemaddr = 32'h80; #1;
        checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL conf_miss80: got %b exp 0", bus.ihit); end
        cyc(); bus.iwait = 1'b0; bus.iload = 32'h1111_1111; #1;
        checks++; if (bus.iaddr !== 32'h80) begin errors++; $display("FAIL conf_iaddr: got %h exp 00000080", bus.iaddr); end
        cyc(); bus.iwait = 1'b1; #1;
        checks++; if (bus.imemload !== 32'h1111_1111) begin errors++; $display("FAIL conf_data80: got %h exp 11111111", bus.imemload); end
        cyc(); bus.imemaddr = 32'h40; #1;
        checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL conf_miss40: got %b exp 0", bus.ihit); end
        cyc(); bus.imemREN = 1'b0; #1;
        checks++; if (miss_count !== 16'd3) begin errors++; $display("FAIL conf_misses: got %0d exp 3", miss_count); end
        checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL conf_abort_iren: got %b exp 0", bus.iREN); end
        cyc(); bus.imemREN = 1'b1; bus.imemaddr = 32'h80; #1;
        checks++; if (bus.imemload !== 32'h1111_1111) begin errors++; $display("FAIL conf_rehit80: got %h exp 11111111", bus.imemload); end
        cyc(); bus.imemREN = 1'b0; #1;
        checks++; if (hit_count !== 16'd4) begin errors++; $display("FAIL conf_hits: got %0d exp 4", hit_count); end
    endtask

    task automatic test_abort();
        cyc(); bus.imemREN = 1'b1; bus.imemaddr = 32'h104; bus.iwait = 1'b1; #1;
        checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL abort_miss: got %b exp 0", bus.ihit); end
        cyc(); #1;
        checks++; if (bus.iREN !== 1'b1) begin errors++; $display("FAIL abort_iren_on: got %b exp 1", bus.iREN); end
        cyc(); bus.imemREN = 1'b0; #1;
        checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL abort_iren_drop: got %b exp 0", bus.iREN); end
        cyc(); bus.iwait = 1'b0; bus.iload = 32'h0000_0BAD; #1;
        checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL abort_iren_idle: got %b exp 0", bus.iREN); end
        cyc(); bus.iwait = 1'b1; bus.imemREN = 1'b1; #1;
        checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL abort_nofill: got %b exp 0", bus.ihit); end
        checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL abort_state_idle: got %b exp 0", bus.iREN); end
        cyc(); bus.imemREN = 1'b0; #1;
        checks++; if (miss_count !== 16'd5) begin errors++; $display("FAIL abort_misses: got %0d exp 5", miss_count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) fill(32'h200 + 32'(i * 4), 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            cyc(); bus.imemREN = 1'b1; bus.imemaddr = 32'h200 + 32'(i * 4); #1;
            checks++; if (bus.imemload !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL flush_prefill%0d: got %h exp %h", i, bus.imemload, 32'hA0 + 32'(i)); end
        end
        cyc(); bus.imemREN = 1'b0; #1;
        checks++; if (hit_count !== 16'd8) begin errors++; $display("FAIL flush_hits: got %0d exp 8", hit_count); end
        checks++; if (miss_count !== 16'd9) begin errors++; $display("FAIL flush_misses9: got %0d exp 9", miss_count); end
        cyc(); bus.flush = 1'b1; bus.imemREN = 1'b1; bus.imemaddr = 32'h200; #1;
        checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL flush_mask: got %b exp 0", bus.ihit); end
        cyc(); bus.flush = 1'b0; bus.imemREN = 1'b0; #1;
        checks++; if (miss_count !== 16'd9) begin errors++; $display("FAIL flush_nomiss: got %0d exp 9", miss_count); end
        for (int i = 0; i < 4; i++) begin
            cyc(); bus.imemREN = 1'b1; bus.imemaddr = 32'h200 + 32'(i * 4); #1;
            checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL flush_remiss%0d: got %b exp 0", i, bus.ihit); end
            cyc(); bus.imemREN = 1'b0;
        end
        #1;
        checks++; if (miss_count !== 16'd13) begin errors++; $display("FAIL flush_misses13: got %0d exp 13", miss_count); end
        cyc(); bus.imemREN = 1'b1; bus.imemaddr = 32'h300; bus.iwait = 1'b1;
        cyc(); bus.iwait = 1'b0; bus.iload = 32'h5555_5555; bus.flush = 1'b1; #1;
        checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL flush_fetch_iren: got %b exp 0", bus.iREN); end
        cyc(); bus.flush = 1'b0; bus.iwait = 1'b1; #1;
        checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL flush_fetch_nofill: got %b exp 0", bus.ihit); end
        checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL flush_fetch_idle: got %b exp 0", bus.iREN); end
        cyc(); bus.imemREN = 1'b0; #1;
        checks++; if (miss_count !== 16'd15) begin errors++; $display("FAIL flush_misses15: got %0d exp 15", miss_count); end
    endtask

    task automatic test_reset_mid_miss();
        cyc(); bus.imemREN = 1'b1; bus.imemaddr = 32'h40; bus.iwait = 1'b1;
        cyc(); #1;
        checks++; if (bus.iREN !== 1'b1) begin errors++; $display("FAIL rmid_iren_on: got %b exp 1", bus.iREN); end
        cyc(); RST = 1'b1; bus.iwait = 1'b0; bus.iload = 32'h7777_7777; #1;
        checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL rmid_iren_rst: got %b exp 0", bus.iREN); end
        cyc(); RST = 1'b0; bus.iwait = 1'b1; #1;
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL rmid_hits: got %0d exp 0", hit_count); end
        checks++; if (miss_count !== 16'd0) begin errors++; $display("FAIL rmid_misses0: got %0d exp 0", miss_count); end
        checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL rmid_nofill: got %b exp 0", bus.ihit); end
        checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %b exp 0", bus.iREN); end
        cyc(); bus.imemREN = 1'b0; #1;
        checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL rmid_misses1: got %0d exp 1", miss_count); end
    endtask

    task automatic test_saturation();
        fill(32'h40, 32'hCAFE_F00D);
        cyc(); bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
        repeat (65534) cyc();
        #1;
        checks++; if (hit_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h exp fffe", hit_count); end
        repeat (6) cyc();
        #1;
        checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h exp ffff", hit_count); end
        checks++; if (bus.imemload !== 32'hCAFE_F00D) begin errors++; $display("FAIL sat_data: got %h exp cafef00d", bus.imemload); end
        cyc(); bus.imemREN = 1'b0; #1;
        checks++; if (miss_count !== 16'd2) begin errors++; $display("FAIL sat_misses: got %0d exp 2", miss_count); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_abort();
        test_flush();
        test_reset_mid_miss();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
